// File: rtl/parking_slot_allocator.sv
// parking_slot_allocator: gate sequencer and slot allocator for the parking FSM.
// Arbitrates entry/exit requests round-robin, allocates the lowest free slot,
// tracks occupancy/free count and times the door-open window.
// Optional build macro FULL_FLASH_EN: makes `full` flash while a car waits at a
// full lot; without it `full` is the steady "no free slot" level.
module parking_slot_allocator #(
    parameter int N_SLOTS       = 4,
    parameter int SLOT_W        = 2,
    parameter int CNT_W         = 3,
    parameter int GATE_OPEN_CYC = 8,
    parameter int FLASH_DIV     = 4
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               entry_req_i,
    input  logic               exit_req_i,
    input  logic [SLOT_W-1:0]  exit_slot_i,
    output logic               entry_grant_o,
    output logic               exit_grant_o,
    output logic [SLOT_W-1:0]  grant_slot_o,
    output logic               exit_err_o,
    output logic [N_SLOTS-1:0] occupancy_o,
    output logic [CNT_W-1:0]   free_cnt_o,
    output logic               door_open_o,
    output logic               full_o,
    output logic               busy_o
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_GRANT = 2'd1;
    localparam logic [1:0] S_OPEN  = 2'd2;
    localparam logic [1:0] S_CLOSE = 2'd3;

    localparam int OPEN_W = (GATE_OPEN_CYC > 2) ? $clog2(GATE_OPEN_CYC) : 1;

    localparam logic LS_ENTRY = 1'b0;
    localparam logic LS_EXIT  = 1'b1;

    logic [1:0]         state_q;
    logic [OPEN_W-1:0]  open_cnt_q;
    logic [N_SLOTS-1:0] occupancy_q, occupancy_d;
    logic [CNT_W-1:0]   free_cnt_q, free_cnt_d;
    logic               lvl_full_q;
    logic               last_served_q;
    logic               entry_grant_q, exit_grant_q, exit_err_q, door_open_q;
    logic [SLOT_W-1:0]  grant_slot_q;

    logic [SLOT_W-1:0]  free_idx;
    logic               slot_occ;
    logic               entry_ok, exit_ok, serve_entry, serve_exit, is_idle;

    // Lowest-index free slot: scan downwards so the smallest index wins.
    always_comb begin
        free_idx = '0;
        for (int i = N_SLOTS - 1; i >= 0; i--) begin
            if (!occupancy_q[i]) free_idx = SLOT_W'(i);
        end
    end

    // Eligibility and round-robin pick; the internal steady full level gates
    // entries so a flashing `full` output can never let a car in at zero slots.
    always_comb begin
        is_idle     = (state_q == S_IDLE);
        slot_occ    = occupancy_q[exit_slot_i];
        entry_ok    = is_idle & entry_req_i & ~lvl_full_q;
        exit_ok     = is_idle & exit_req_i & slot_occ;
        serve_entry = entry_ok & (~exit_ok | (last_served_q == LS_EXIT));
        serve_exit  = exit_ok & ~serve_entry;
    end

    // Next occupancy and free count, committed on the edge that raises a grant.
    always_comb begin
        occupancy_d = occupancy_q;
        free_cnt_d  = free_cnt_q;
        if (serve_entry) begin
            occupancy_d[free_idx] = 1'b1;
            free_cnt_d            = free_cnt_q - CNT_W'(1);
        end else if (serve_exit) begin
            occupancy_d[exit_slot_i] = 1'b0;
            free_cnt_d               = free_cnt_q + CNT_W'(1);
        end
    end

    // Gate sequencer: IDLE -> GRANT -> OPEN (GATE_OPEN_CYC cycles) -> CLOSE.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q       <= S_IDLE;
            open_cnt_q    <= '0;
            occupancy_q   <= '0;
            free_cnt_q    <= CNT_W'(N_SLOTS);
            lvl_full_q    <= 1'b0;
            last_served_q <= LS_EXIT;
            entry_grant_q <= 1'b0;
            exit_grant_q  <= 1'b0;
            exit_err_q    <= 1'b0;
            door_open_q   <= 1'b0;
            grant_slot_q  <= '0;
        end else begin
            entry_grant_q <= 1'b0;
            exit_grant_q  <= 1'b0;
            exit_err_q    <= 1'b0;
            occupancy_q   <= occupancy_d;
            free_cnt_q    <= free_cnt_d;
            lvl_full_q    <= (free_cnt_d == '0);
            case (state_q)
                S_IDLE: begin
                    // A bad exit slot is reported even if an entry is served alongside.
                    if (exit_req_i && !slot_occ) exit_err_q <= 1'b1;
                    if (serve_entry) begin
                        entry_grant_q <= 1'b1;
                        grant_slot_q  <= free_idx;
                        last_served_q <= LS_ENTRY;
                        state_q       <= S_GRANT;
                    end else if (serve_exit) begin
                        exit_grant_q  <= 1'b1;
                        grant_slot_q  <= exit_slot_i;
                        last_served_q <= LS_EXIT;
                        state_q       <= S_GRANT;
                    end
                end
                S_GRANT: begin
                    door_open_q <= 1'b1;
                    open_cnt_q  <= '0;
                    state_q     <= S_OPEN;
                end
                S_OPEN: begin
                    if (open_cnt_q == OPEN_W'(GATE_OPEN_CYC - 1)) begin
                        door_open_q <= 1'b0;
                        state_q     <= S_CLOSE;
                    end else begin
                        open_cnt_q <= open_cnt_q + OPEN_W'(1);
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

`ifdef FULL_FLASH_EN
    localparam int FL_W = $clog2(FLASH_DIV + 1);

    logic [FL_W-1:0] flash_cnt_q;
    logic            flash_phase_q;
    logic            flash_on;

    assign flash_on = lvl_full_q & entry_req_i;

    // Flash timer: phase starts lit and inverts every FLASH_DIV cycles.
    always_ff @(posedge clk_i) begin
        if (reset_i || !flash_on) begin
            flash_cnt_q   <= '0;
            flash_phase_q <= 1'b1;
        end else if (flash_cnt_q == FL_W'(FLASH_DIV - 1)) begin
            flash_cnt_q   <= '0;
            flash_phase_q <= ~flash_phase_q;
        end else begin
            flash_cnt_q <= flash_cnt_q + FL_W'(1);
        end
    end

    assign full_o = lvl_full_q & (flash_phase_q | ~entry_req_i);
`else
    assign full_o = lvl_full_q;
`endif

    assign entry_grant_o = entry_grant_q;
    assign exit_grant_o  = exit_grant_q;
    assign grant_slot_o  = grant_slot_q;
    assign exit_err_o    = exit_err_q;
    assign occupancy_o   = occupancy_q;
    assign free_cnt_o    = free_cnt_q;
    assign door_open_o   = door_open_q;
    assign busy_o        = (state_q != S_IDLE);

endmodule
